// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by the fetch FSM and its instruction queue.
package instr_fetch_pkg;

    localparam int ADDR_WIDTH      = 32;
    localparam int INSTR_WIDTH     = 32;
    localparam int DEF_QUEUE_DEPTH = 4;

    typedef enum logic [1:0] {
        IF_IDLE    = 2'd0,
        IF_BUSY    = 2'd1,
        IF_DISCARD = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ADDR_WIDTH-1:0] word_align(
        input logic [ADDR_WIDTH-1:0] addr
    );
        return {addr[ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_queue.sv
// Circular FIFO of {pc, instr} entries between fetch and decode.
// Head entry is read straight from registered storage.
module instr_queue
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = DEF_QUEUE_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head_entry,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic            do_push;
    logic            do_pop;

    assign do_pop     = pop && (count != '0);
    assign do_push    = push && ((count != CW'(DEPTH)) || do_pop);
    assign head_entry = mem[head];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[tail] <= push_entry;
                tail      <= tail + PW'(1);
            end
            if (do_pop) begin
                head <= head + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding I-cache request, queued results to decode.
// Redirects flush the queue and drop any response still in flight.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
    parameter int                    QUEUE_DEPTH = DEF_QUEUE_DEPTH
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    output logic                   ic_req_valid,
    output logic [ADDR_WIDTH-1:0]  ic_req_addr,
    input  logic                   ic_resp_valid,
    input  logic [INSTR_WIDTH-1:0] ic_resp_instr,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0]  pc_out,
    input  logic                   instr_ready,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    if_state_e              state;
    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic [CW-1:0]          q_count;
    fetch_entry_t           q_head;
    fetch_entry_t           q_push_entry;
    logic                   q_push;
    logic                   q_pop;
    logic                   not_full;

    assign not_full     = q_count < CW'(QUEUE_DEPTH);
    assign q_push       = (state == IF_BUSY) && ic_resp_valid && !redirect_valid;
    assign q_pop        = instr_valid && instr_ready;
    assign q_push_entry = '{pc: fetch_pc, instr: ic_resp_instr};

    assign instr_valid  = (q_count != '0);
    assign instr_out    = q_head.instr;
    assign pc_out       = q_head.pc;

    instr_queue #(
        .DEPTH (QUEUE_DEPTH),
        .CW    (CW)
    ) u_queue (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .push       (q_push),
        .push_entry (q_push_entry),
        .pop        (q_pop),
        .flush      (redirect_valid),
        .head_entry (q_head),
        .count      (q_count)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= IF_IDLE;
            fetch_pc     <= RESET_PC;
            ic_req_valid <= 1'b0;
            ic_req_addr  <= RESET_PC;
        end else begin
            unique case (state)
                IF_IDLE: begin
                    if (redirect_valid) begin
                        fetch_pc <= word_align(redirect_pc);
                    end else if (not_full) begin
                        state        <= IF_BUSY;
                        ic_req_valid <= 1'b1;
                        ic_req_addr  <= fetch_pc;
                    end
                end
                IF_BUSY: begin
                    if (redirect_valid) begin
                        fetch_pc <= word_align(redirect_pc);
                        if (ic_resp_valid) begin
                            state        <= IF_IDLE;
                            ic_req_valid <= 1'b0;
                        end else begin
                            state <= IF_DISCARD;
                        end
                    end else if (ic_resp_valid) begin
                        fetch_pc     <= fetch_pc + 32'd4;
                        state        <= IF_IDLE;
                        ic_req_valid <= 1'b0;
                    end
                end
                IF_DISCARD: begin
                    if (redirect_valid) begin
                        fetch_pc <= word_align(redirect_pc);
                    end
                    // The stale response only releases the port; it is never queued.
                    if (ic_resp_valid) begin
                        state        <= IF_IDLE;
                        ic_req_valid <= 1'b0;
                    end
                end
                default: begin
                    state        <= IF_IDLE;
                    ic_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: vector table, directed corners,
// and a randomized run checked against an instruction-stream model.
module tb_instr_fetch;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        ic_req_valid;
    logic [31:0] ic_req_addr;
    logic        ic_resp_valid;
    logic [31:0] ic_resp_instr;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (4)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .ic_req_valid   (ic_req_valid),
        .ic_req_addr    (ic_req_addr),
        .ic_resp_valid  (ic_resp_valid),
        .ic_resp_instr  (ic_resp_instr),
        .instr_valid    (instr_valid),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        resp;
        logic [31:0] rinstr;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic        chk_data;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic vec_t mk(
        input logic resp, input logic [31:0] rinstr, input logic ready,
        input logic e_req, input logic [31:0] e_addr, input logic e_valid,
        input logic chk_data, input logic [31:0] e_instr, input logic [31:0] e_pc
    );
        vec_t v;
        v.resp = resp; v.rinstr = rinstr; v.ready = ready;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.chk_data = chk_data; v.e_instr = e_instr; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs;
        ic_resp_valid  = 1'b0;
        ic_resp_instr  = 32'h0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_n_in = 1'b0;
        tick();
        tick();
        rst_n_in = 1'b1;
    endtask

    task automatic wait_req(input string nm, input logic [31:0] exp_addr);
        int n = 0;
        while (!ic_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk({nm, "_req"}, 32'(ic_req_valid), 32'd1);
        chk({nm, "_addr"}, ic_req_addr, exp_addr);
    endtask

    task automatic respond(input logic [31:0] w);
        tick();
        ic_resp_valid = 1'b1;
        ic_resp_instr = w;
        tick();
        ic_resp_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_n_in = 1'b0;
        #23;
        chk("rst_req_valid", 32'(ic_req_valid), 32'd0);
        chk("rst_req_addr", ic_req_addr, 32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr_out", instr_out, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        tick();
        rst_n_in = 1'b1;

        // fill to full with decode stalled, then drain with push/pop overlap
        tbl.push_back(mk(0, 0, 0, 1, 32'h00, 0, 1, 32'h0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h00, 0, 1, 32'h0, 32'h0));
        tbl.push_back(mk(1, imem(32'h00), 0, 0, 32'h00, 1, 1, imem(32'h00), 32'h00));
        tbl.push_back(mk(0, 0, 0, 1, 32'h04, 1, 1, imem(32'h00), 32'h00));
        tbl.push_back(mk(0, 0, 0, 1, 32'h04, 1, 1, imem(32'h00), 32'h00));
        tbl.push_back(mk(1, imem(32'h04), 0, 0, 32'h04, 1, 1, imem(32'h00), 32'h00));
        tbl.push_back(mk(0, 0, 0, 1, 32'h08, 1, 1, imem(32'h00), 32'h00));
        tbl.push_back(mk(0, 0, 0, 1, 32'h08, 1, 1, imem(32'h00), 32'h00));
        tbl.push_back(mk(1, imem(32'h08), 0, 0, 32'h08, 1, 1, imem(32'h00), 32'h00));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0C, 1, 1, imem(32'h00), 32'h00));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0C, 1, 1, imem(32'h00), 32'h00));
        tbl.push_back(mk(1, imem(32'h0C), 0, 0, 32'h0C, 1, 1, imem(32'h00), 32'h00));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0C, 1, 1, imem(32'h00), 32'h00));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0C, 1, 1, imem(32'h00), 32'h00));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0C, 1, 1, imem(32'h04), 32'h04));
        tbl.push_back(mk(0, 0, 0, 1, 32'h10, 1, 1, imem(32'h04), 32'h04));
        tbl.push_back(mk(0, 0, 0, 1, 32'h10, 1, 1, imem(32'h04), 32'h04));
        tbl.push_back(mk(1, imem(32'h10), 1, 0, 32'h10, 1, 1, imem(32'h08), 32'h08));
        tbl.push_back(mk(0, 0, 1, 1, 32'h14, 1, 1, imem(32'h0C), 32'h0C));
        tbl.push_back(mk(0, 0, 1, 1, 32'h14, 1, 1, imem(32'h10), 32'h10));
        tbl.push_back(mk(0, 0, 1, 1, 32'h14, 0, 0, 32'h0, 32'h0));
        tbl.push_back(mk(1, imem(32'h14), 0, 0, 32'h14, 1, 1, imem(32'h14), 32'h14));

        foreach (tbl[i]) begin
            ic_resp_valid = tbl[i].resp;
            ic_resp_instr = tbl[i].rinstr;
            instr_ready   = tbl[i].ready;
            tick();
            chk($sformatf("v%0d_req_valid", i), 32'(ic_req_valid), 32'(tbl[i].e_req));
            chk($sformatf("v%0d_req_addr", i), ic_req_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_instr_valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
            if (tbl[i].chk_data) begin
                chk($sformatf("v%0d_instr_out", i), instr_out, tbl[i].e_instr);
                chk($sformatf("v%0d_pc_out", i), pc_out, tbl[i].e_pc);
            end
        end
        idle_inputs();

        // redirect while a request is outstanding: old response is dropped
        do_reset();
        wait_req("d3_a", 32'h0);
        respond(imem(32'h0));
        wait_req("d3_b", 32'h4);
        respond(imem(32'h4));
        wait_req("d3_c", 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        tick();
        redirect_valid = 1'b0;
        chk("d3_hold_valid", 32'(ic_req_valid), 32'd1);
        chk("d3_hold_addr", ic_req_addr, 32'h8);
        chk("d3_flushed", 32'(instr_valid), 32'd0);
        tick();
        chk("d3_hold2_addr", ic_req_addr, 32'h8);
        ic_resp_valid = 1'b1;
        ic_resp_instr = 32'hDEAD_BEEF;
        tick();
        ic_resp_valid = 1'b0;
        chk("d3_drop_req", 32'(ic_req_valid), 32'd0);
        chk("d3_drop_valid", 32'(instr_valid), 32'd0);
        wait_req("d3_new", 32'h80);
        respond(imem(32'h80));
        chk("d3_q_valid", 32'(instr_valid), 32'd1);
        chk("d3_q_pc", pc_out, 32'h80);
        chk("d3_q_instr", instr_out, imem(32'h80));

        // redirect coinciding with response and pop; low pc bits ignored
        wait_req("d5_a", 32'h84);
        tick();
        ic_resp_valid  = 1'b1;
        ic_resp_instr  = imem(32'h84);
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h83;
        tick();
        idle_inputs();
        chk("d5_empty", 32'(instr_valid), 32'd0);
        chk("d5_req_low", 32'(ic_req_valid), 32'd0);
        tick();
        chk("d5_req", 32'(ic_req_valid), 32'd1);
        chk("d5_addr", ic_req_addr, 32'h80);
        respond(imem(32'h80));
        chk("d5_q_pc", pc_out, 32'h80);

        // asynchronous reset while busy with two entries queued
        wait_req("d6_a", 32'h84);
        respond(imem(32'h84));
        wait_req("d6_b", 32'h88);
        chk("d6_pre_valid", 32'(instr_valid), 32'd1);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("d6_rst_req", 32'(ic_req_valid), 32'd0);
        chk("d6_rst_addr", ic_req_addr, 32'h0);
        chk("d6_rst_valid", 32'(instr_valid), 32'd0);
        chk("d6_rst_instr", instr_out, 32'h0);
        chk("d6_rst_pc", pc_out, 32'h0);
        tick();
        rst_n_in = 1'b1;
        tick();
        chk("d6_restart_req", 32'(ic_req_valid), 32'd1);
        chk("d6_restart_addr", ic_req_addr, 32'h0);

        // randomized run against the expected instruction stream
        begin
            logic [31:0] exp_pc;
            logic [31:0] paddr;
            logic        pending;
            int          lat;
            int          pops;
            do_reset();
            exp_pc  = 32'h0;
            pending = 1'b0;
            lat     = 0;
            pops    = 0;
            for (int c = 0; c < 3000; c++) begin
                idle_inputs();
                if (pending) begin
                    chk("r_req_held", 32'(ic_req_valid), 32'd1);
                    chk("r_addr_held", ic_req_addr, paddr);
                    if (lat == 0) begin
                        ic_resp_valid = 1'b1;
                        ic_resp_instr = imem(paddr);
                        pending       = 1'b0;
                    end else begin
                        lat--;
                    end
                end else if (ic_req_valid) begin
                    pending = 1'b1;
                    paddr   = ic_req_addr;
                    lat     = $urandom_range(3, 1) - 1;
                end
                instr_ready = ($urandom_range(3, 0) != 0);
                if ($urandom_range(19, 0) == 0) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = ($urandom_range(3, 0) == 0)
                                   ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                   : $urandom;
                end
                if (redirect_valid) begin
                    exp_pc = redirect_pc & ~32'h3;
                end else if (instr_valid && instr_ready) begin
                    chk("r_pc", pc_out, exp_pc);
                    chk("r_instr", instr_out, imem(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    pops++;
                end
                tick();
            end
            idle_inputs();
            n_tests++;
            if (pops < 100) begin
                n_fail++;
                $display("FAIL r_progress: got %0d pops expected at least 100", pops);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
